seven_seg_scan_driver: RTL

//  - Time-multiplexed driver for NUM_DIGITS common-anode seven-segment digits (hex 0-F per digit).
//  - Successor to the single-digit combinational decoder: multi-digit, parametrised, scan-timed, tear-free updates.
//  - Sits between any value producer (counter, UART, debug bus) and the board's seg/anode pins.

---
 rtl/seven_seg_scan_driver_pkg.sv | 34 +++
 rtl/seven_seg_decoder.sv | 17 +
 rtl/seven_seg_scan_driver.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/seven_seg_scan_driver_pkg.sv
// Shared definitions for the seven-segment scan driver: hex->segment table
// (active-low gfedcba), blank pattern and polarity helper.
package seven_seg_scan_driver_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  function automatic logic [6:0] hex_to_seg_n(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h18;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  function automatic logic [6:0] seg_off(input bit act_low);
    return act_low ? SEG_BLANK : ~SEG_BLANK;
  endfunction

endpackage

// File: rtl/seven_seg_decoder.sv
// Combinational hex nibble to seven-segment pattern, output polarity set by
// SEG_ACT_LOW.
module seven_seg_decoder
  import seven_seg_scan_driver_pkg::*;
#(
  parameter int SEG_ACT_LOW = 1
) (
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = hex_to_seg_n(nibble);
    if (SEG_ACT_LOW == 0) seg = ~seg;
  end

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed multi-digit seven-segment driver with frame-aligned updates.
// Optional decimal point support is enabled by defining SEG_DP_EN.
module seven_seg_scan_driver
  import seven_seg_scan_driver_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int SEG_ACT_LOW = 1,
  parameter int AN_ACT_LOW  = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
`ifdef SEG_DP_EN
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic                    dp,
`endif
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    pending,
  output logic                    frame_done
);

  localparam int DIV_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [6:0] SEG_OFF = seg_off(SEG_ACT_LOW != 0);
  localparam logic [NUM_DIGITS-1:0] AN_OFF = (AN_ACT_LOW != 0) ? '1 : '0;

  logic [DIV_W-1:0]        div_cnt_q, div_cnt_d;
  logic [IDX_W-1:0]        dig_idx_q, dig_idx_d;
  logic [4*NUM_DIGITS-1:0] pend_val_q, pend_val_d, act_val_q, act_val_d;
  logic [NUM_DIGITS-1:0]   pend_blank_q, pend_blank_d, act_blank_q, act_blank_d;
  logic                    pending_q, pending_d, disp_valid_q, disp_valid_d;
  logic [6:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    frame_done_q, frame_done_d;
  logic [3:0]              nibble;
  logic [6:0]              dec_seg;
  logic [NUM_DIGITS-1:0]   onehot;
  logic                    sel_blank, wrap, boundary, show;
`ifdef SEG_DP_EN
  logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d, act_dp_q, act_dp_d;
  logic                    dp_q, dp_d, sel_dp;
`endif

  // Digit select: explicit compare loop keeps non-power-of-two counts in range
  always_comb begin
    nibble    = '0;
    sel_blank = 1'b1;
    onehot    = '0;
`ifdef SEG_DP_EN
    sel_dp    = 1'b0;
`endif
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (dig_idx_q == IDX_W'(k)) begin
        nibble    = act_val_q[k*4 +: 4];
        sel_blank = act_blank_q[k];
        onehot[k] = 1'b1;
`ifdef SEG_DP_EN
        sel_dp    = act_dp_q[k];
`endif
      end
    end
  end

  seven_seg_decoder #(.SEG_ACT_LOW(SEG_ACT_LOW)) u_dec (
    .nibble (nibble),
    .seg    (dec_seg)
  );

  always_comb begin
    wrap         = (div_cnt_q == DIV_LAST);
    boundary     = wrap && (dig_idx_q == IDX_LAST);
    div_cnt_d    = wrap ? '0 : div_cnt_q + 1'b1;
    dig_idx_d    = dig_idx_q;
    if (wrap) dig_idx_d = (dig_idx_q == IDX_LAST) ? '0 : dig_idx_q + 1'b1;

    pend_val_d   = pend_val_q;
    pend_blank_d = pend_blank_q;
    pending_d    = pending_q && !boundary;
    if (load) begin
      pend_val_d   = value;
      pend_blank_d = blank_mask;
      pending_d    = 1'b1;
    end

    // The active set only changes on a frame boundary so a frame never tears
    act_val_d    = act_val_q;
    act_blank_d  = act_blank_q;
    disp_valid_d = disp_valid_q;
    if (boundary && pending_q) begin
      act_val_d    = pend_val_q;
      act_blank_d  = pend_blank_q;
      disp_valid_d = 1'b1;
    end

    show         = disp_valid_q && (div_cnt_q != '0) && !sel_blank;
    an_d         = show ? ((AN_ACT_LOW != 0) ? ~onehot : onehot) : AN_OFF;
    seg_d        = show ? dec_seg : SEG_OFF;
    frame_done_d = boundary;
  end

`ifdef SEG_DP_EN
  always_comb begin
    pend_dp_d = load ? dp_in : pend_dp_q;
    act_dp_d  = (boundary && pending_q) ? pend_dp_q : act_dp_q;
    dp_d      = (show && sel_dp) ? (SEG_ACT_LOW == 0) : (SEG_ACT_LOW != 0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_dp_q <= '0;
      act_dp_q  <= '0;
      dp_q      <= (SEG_ACT_LOW != 0);
    end else begin
      pend_dp_q <= pend_dp_d;
      act_dp_q  <= act_dp_d;
      dp_q      <= dp_d;
    end
  end

  assign dp = dp_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q    <= '0;
      dig_idx_q    <= '0;
      pend_val_q   <= '0;
      pend_blank_q <= '0;
      pending_q    <= 1'b0;
      act_val_q    <= '0;
      act_blank_q  <= '0;
      disp_valid_q <= 1'b0;
      seg_q        <= SEG_OFF;
      an_q         <= AN_OFF;
      frame_done_q <= 1'b0;
    end else begin
      div_cnt_q    <= div_cnt_d;
      dig_idx_q    <= dig_idx_d;
      pend_val_q   <= pend_val_d;
      pend_blank_q <= pend_blank_d;
      pending_q    <= pending_d;
      act_val_q    <= act_val_d;
      act_blank_q  <= act_blank_d;
      disp_valid_q <= disp_valid_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign pending    = pending_q;
  assign frame_done = frame_done_q;

endmodule
